// File: rtl/text_buffer_if.sv
// rtl/text_buffer_if.sv - write stream, read port and status bundle for text_buffer
interface text_buffer_if #(
    parameter int SIZE_X = 16,
    parameter int SIZE_Y = 8
);
    localparam int XW = $clog2(SIZE_X);
    localparam int YW = $clog2(SIZE_Y);

    logic          wr_valid;
    logic          wr_ready;
    logic [6:0]    wr_char;
    logic          clear;
    logic [XW-1:0] char_x;
    logic [YW-1:0] char_y;
    logic [6:0]    char_code;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          busy;

    modport master (
        output wr_valid, wr_char, clear, char_x, char_y,
        input  wr_ready, char_code, cursor_x, cursor_y, busy
    );

    modport slave (
        input  wr_valid, wr_char, clear, char_x, char_y,
        output wr_ready, char_code, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - scrolling character grid with cursor write port and registered read port
module text_buffer #(
    parameter int SIZE_X = 16,
    parameter int SIZE_Y = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    text_buffer_if.slave  bus
);
    localparam int XW = $clog2(SIZE_X);
    localparam int YW = $clog2(SIZE_Y);
    localparam int N  = SIZE_X * SIZE_Y;
    localparam int AW = $clog2(N);
    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL} state_t;

    state_t        r_state;
    logic [AW-1:0] r_idx;
    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic [YW-1:0] r_top;
    logic [YW-1:0] r_scroll_row;
    logic          r_busy;
    logic          r_ready;
    logic [6:0]    r_code;
    logic [6:0]    r_mem [N];

    logic          w_accept;
    logic          w_printable;
    logic          w_lf;
    logic          w_oob;
    logic          w_we;
    logic [YW-1:0] w_rd_row;
    logic [YW-1:0] w_wr_row;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_waddr;
    logic [6:0]    w_wdata;

    // Screen row to physical row; SIZE_Y need not be a power of two.
    function automatic logic [YW-1:0] wrap_row(input logic [YW-1:0] a, input logic [YW-1:0] b);
        logic [YW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (YW+1)'(SIZE_Y))
            s = s - (YW+1)'(SIZE_Y);
        return s[YW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row, input logic [XW-1:0] col);
        return AW'(row) * AW'(SIZE_X) + AW'(col);
    endfunction

    assign bus.wr_ready = r_ready && !bus.clear;
    assign bus.busy     = r_busy;
    assign bus.cursor_x = r_cx;
    assign bus.cursor_y = r_cy;
    assign bus.char_code = r_code;

    assign w_accept    = bus.wr_valid && bus.wr_ready;
    assign w_printable = (bus.wr_char >= 7'h20) && (bus.wr_char <= 7'h7E);
    assign w_lf        = (w_printable && (r_cx == XW'(SIZE_X-1))) || (bus.wr_char == 7'h0A);
    assign w_oob       = ({1'b0, bus.char_x} >= (XW+1)'(SIZE_X)) ||
                         ({1'b0, bus.char_y} >= (YW+1)'(SIZE_Y));
    assign w_rd_row    = wrap_row(bus.char_y, r_top);
    assign w_rd_addr   = w_oob ? '0 : cell_addr(w_rd_row, bus.char_x);
    assign w_wr_row    = wrap_row(r_cy, r_top);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = SPACE;
        if (!bus.clear) begin
            case (r_state)
                S_CLEAR: begin
                    w_we    = 1'b1;
                    w_waddr = r_idx;
                end
                S_SCROLL: begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(r_scroll_row, r_idx[XW-1:0]);
                end
                S_IDLE: begin
                    if (w_accept && w_printable) begin
                        w_we    = 1'b1;
                        w_waddr = cell_addr(w_wr_row, r_cx);
                        w_wdata = bus.wr_char;
                    end
                end
                default: w_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Nonblocking read of the array gives read-before-write on a same-cell collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_code <= '0;
        else
            r_code <= w_oob ? SPACE : r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEAR;
            r_idx        <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_top        <= '0;
            r_scroll_row <= '0;
            r_busy       <= 1'b1;
            r_ready      <= 1'b0;
        end else if (bus.clear) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_top   <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_idx == AW'(N-1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_SCROLL: begin
                    if (r_idx == AW'(SIZE_X-1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_printable)
                            r_cx <= w_lf ? '0 : r_cx + 1'b1;
                        else if ((bus.wr_char == 7'h0A) || (bus.wr_char == 7'h0D))
                            r_cx <= '0;
                        else if ((bus.wr_char == 7'h08) && (r_cx != '0))
                            r_cx <= r_cx - 1'b1;
                        // Line feed on the last row rotates the window; the old top row becomes the blank bottom.
                        if (w_lf) begin
                            if (r_cy != YW'(SIZE_Y-1)) begin
                                r_cy <= r_cy + 1'b1;
                            end else begin
                                r_top        <= wrap_row(r_top, YW'(1));
                                r_scroll_row <= r_top;
                                r_idx        <= '0;
                                r_state      <= S_SCROLL;
                                r_busy       <= 1'b1;
                                r_ready      <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - self-checking bench for text_buffer
module tb_text_buffer;
    localparam int SX = 16;
    localparam int SY = 8;
    localparam int XW = $clog2(SX);
    localparam int YW = $clog2(SY);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    text_buffer_if #(.SIZE_X(SX), .SIZE_Y(SY)) bus();

    text_buffer #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         due;
        int         x;
        int         y;
        logic [6:0] exp;
    } rd_t;
    rd_t sb[$];
    rd_t sb_e;

    typedef struct {
        logic [6:0] ch;
        int         ex;
        int         ey;
    } vec_t;
    vec_t tv[7];

    logic [6:0] m_scr [SY][SX];
    int m_cx;
    int m_cy;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int y = 0; y < SY; y++)
            for (int x = 0; x < SX; x++)
                m_scr[y][x] = 7'h20;
        m_cx = 0;
        m_cy = 0;
    endtask

    task automatic m_lf();
        if (m_cy < SY-1) begin
            m_cy++;
        end else begin
            for (int y = 0; y < SY-1; y++)
                for (int x = 0; x < SX; x++)
                    m_scr[y][x] = m_scr[y+1][x];
            for (int x = 0; x < SX; x++)
                m_scr[SY-1][x] = 7'h20;
        end
    endtask

    task automatic m_put(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            m_scr[m_cy][m_cx] = c;
            if (m_cx == SX-1) begin
                m_cx = 0;
                m_lf();
            end else begin
                m_cx++;
            end
        end else if (c == 7'h0A) begin
            m_cx = 0;
            m_lf();
        end else if (c == 7'h0D) begin
            m_cx = 0;
        end else if (c == 7'h08 && m_cx > 0) begin
            m_cx--;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic wr(input logic [6:0] c);
        int n;
        n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_char  = c;
        while (!bus.wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", (n < 500) ? 1 : 0, 1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        m_put(c);
    endtask

    task automatic rd(input int x, input int y, input logic [6:0] exp);
        bus.char_x = XW'(x);
        bus.char_y = YW'(y);
        sb.push_back('{cyc + 1, x, y, exp});
        @(negedge clk);
    endtask

    task automatic read_grid();
        for (int y = 0; y < SY; y++)
            for (int x = 0; x < SX; x++)
                rd(x, y, m_scr[y][x]);
        @(negedge clk);
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_cursor(input string name, input int ex, input int ey);
        check({name, "_cx"}, int'(bus.cursor_x), ex);
        check({name, "_cy"}, int'(bus.cursor_y), ey);
    endtask

    task automatic pulse_clear();
        int cnt;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        m_clear();
        wait_busy(cnt);
        check("clear_cycles", cnt, SX*SY);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            sb_e = sb.pop_front();
            check($sformatf("cell(%0d,%0d)", sb_e.x, sb_e.y), int'(bus.char_code), int'(sb_e.exp));
        end
    end

    initial begin
        int cnt;
        int c0;
        bus.wr_valid = 1'b0;
        bus.wr_char  = 7'h00;
        bus.clear    = 1'b0;
        bus.char_x   = '0;
        bus.char_y   = '0;
        m_clear();

        tv[0] = '{7'h08, 1, 0};
        tv[1] = '{7'h69, 2, 0};
        tv[2] = '{7'h7F, 2, 0};
        tv[3] = '{7'h0D, 0, 0};
        tv[4] = '{7'h01, 0, 0};
        tv[5] = '{7'h68, 1, 0};
        tv[6] = '{7'h0A, 0, 1};

        repeat (2) @(negedge clk);
        check("rst_char_code", int'(bus.char_code), 0);
        check_cursor("rst", 0, 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_wr_ready", int'(bus.wr_ready), 0);

        rst_n = 1'b1;
        wait_busy(cnt);
        check("init_clear_cycles", cnt, SX*SY);
        check("init_wr_ready", int'(bus.wr_ready), 1);
        read_grid();
        check_cursor("init", 0, 0);

        wr(7'h48);
        wr(7'h49);
        rd(1, 0, 7'h49);
        check_cursor("hi", 2, 0);

        for (int i = 0; i < 7; i++) begin
            wr(tv[i].ch);
            check_cursor($sformatf("vec%0d", i), tv[i].ex, tv[i].ey);
        end
        read_grid();

        pulse_clear();
        c0 = cyc;
        repeat (SX) wr(7'h41);
        wr(7'h42);
        check("burst_cycles", cyc - c0, SX + 1);
        check_cursor("wrap", 1, 1);
        repeat (3) wr(7'h08);
        check_cursor("bs", 0, 1);
        read_grid();

        pulse_clear();
        wr(7'h51);
        repeat (SY-1) wr(7'h0A);
        check_cursor("lf7", 0, SY-1);
        wr(7'h58);
        wr(7'h0A);
        check("scroll_busy", int'(bus.busy), 1);
        check("scroll_wr_ready", int'(bus.wr_ready), 0);
        wait_busy(cnt);
        check("scroll_cycles", cnt, SX);
        check_cursor("scroll", 0, SY-1);
        rd(0, 6, 7'h58);
        rd(0, 0, 7'h20);
        rd(5, 7, 7'h20);
        read_grid();

        wr(7'h59);
        wr(7'h0A);
        repeat (5) @(negedge clk);
        bus.clear    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_char  = 7'h5A;
        check("clear_wr_ready", int'(bus.wr_ready), 0);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        m_clear();
        wait_busy(cnt);
        check("abort_clear_cycles", cnt, SX*SY);
        read_grid();
        check_cursor("abort", 0, 0);

        wr(7'h4B);
        wr(7'h4C);
        bus.wr_valid = 1'b1;
        bus.wr_char  = 7'h4D;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_char_code", int'(bus.char_code), 0);
        check_cursor("arst", 0, 0);
        check("arst_busy", int'(bus.busy), 1);
        check("arst_wr_ready", int'(bus.wr_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_valid = 1'b0;
        m_clear();
        wait_busy(cnt);
        check("arst_clear_cycles", cnt, SX*SY);
        read_grid();
        check_cursor("arst_done", 0, 0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
